// File: rtl/branch_predictor_pipem.sv
// rtl/branch_predictor_pipem.sv - direct-mapped BTB with 2-bit counters, registered mispredict/link pulses
// Optional resolved/mispredict statistics counters enabled by BRANCH_PREDICTOR_STATS_EN.
module branch_predictor_pipem #(
  parameter int          INDEX_W  = 6,
  parameter logic [1:0]  INIT_CNT = 2'b01
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iFetchPC,
  output logic        oPredTaken,
  output logic [31:0] oPredTarget,
  input  logic        iResValid,
  input  logic [31:0] iResPC,
  input  logic        iResTaken,
  input  logic        iResLink,
  input  logic [31:0] iResTarget,
  input  logic        iResPredTaken,
  input  logic [31:0] iResPredTarget,
  output logic        oMispredict,
  output logic [31:0] oRedirectPC,
  output logic        oLinkWe,
  output logic [31:0] oLinkPC,
  output logic [31:0] oStatBranches,
  output logic [31:0] oStatMispred
);

  localparam int TAG_W   = 30 - INDEX_W;
  localparam int ENTRIES = 1 << INDEX_W;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [31:0]       r_target [ENTRIES];
  logic [1:0]        r_cnt    [ENTRIES];

  logic [INDEX_W-1:0] w_fidx;
  logic [TAG_W-1:0]   w_ftag;
  logic               w_fhit;
  logic [INDEX_W-1:0] w_ridx;
  logic [TAG_W-1:0]   w_rtag;
  logic               w_rhit;
  logic               w_mis;
  logic [31:0]        w_fpc_plus4;
  logic [31:0]        w_rpc_plus4;
  logic               w_unused;

  assign w_unused = ^{iFetchPC[1:0], iResPC[1:0]};

  assign w_fidx      = iFetchPC[INDEX_W+1:2];
  assign w_ftag      = iFetchPC[31:INDEX_W+2];
  assign w_fhit      = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_fpc_plus4 = iFetchPC + 32'd4;
  assign oPredTaken  = w_fhit & r_cnt[w_fidx][1];
  assign oPredTarget = oPredTaken ? r_target[w_fidx] : w_fpc_plus4;

  assign w_ridx      = iResPC[INDEX_W+1:2];
  assign w_rtag      = iResPC[31:INDEX_W+2];
  assign w_rhit      = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
  assign w_rpc_plus4 = iResPC + 32'd4;

  // A correctly-predicted direction still mispredicts if the taken target changed.
  assign w_mis = (iResTaken != iResPredTaken) |
                 (iResTaken & iResPredTaken & (iResTarget != iResPredTarget));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= INIT_CNT;
      end
    end else if (iResValid) begin
      if (w_rhit && iResTaken) begin
        r_cnt[w_ridx]    <= (r_cnt[w_ridx] == 2'b11) ? 2'b11 : r_cnt[w_ridx] + 2'd1;
        r_target[w_ridx] <= iResTarget;
      end else if (w_rhit) begin
        r_cnt[w_ridx]    <= (r_cnt[w_ridx] == 2'b00) ? 2'b00 : r_cnt[w_ridx] - 2'd1;
      end else if (iResTaken) begin
        r_valid[w_ridx]  <= 1'b1;
        r_tag[w_ridx]    <= w_rtag;
        r_target[w_ridx] <= iResTarget;
        r_cnt[w_ridx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oMispredict <= 1'b0;
      oRedirectPC <= '0;
      oLinkWe     <= 1'b0;
      oLinkPC     <= '0;
    end else begin
      oMispredict <= iResValid & w_mis;
      oLinkWe     <= iResValid & iResTaken & iResLink;
      if (iResValid && w_mis)
        oRedirectPC <= iResTaken ? iResTarget : w_rpc_plus4;
      if (iResValid && iResTaken && iResLink)
        oLinkPC <= iResPC + 32'd8;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (iResValid) begin
      r_stat_br <= r_stat_br + 32'd1;
      if (w_mis)
        r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign oStatBranches = r_stat_br;
  assign oStatMispred  = r_stat_mis;
`else
  assign oStatBranches = 32'h0;
  assign oStatMispred  = 32'h0;
`endif

endmodule

// File: tb/tb_branch_predictor_pipem.sv
// tb/tb_branch_predictor_pipem.sv - vector table plus scoreboard bench for branch_predictor_pipem
module tb_branch_predictor_pipem;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [31:0] iFetchPC = '0;
  logic        oPredTaken;
  logic [31:0] oPredTarget;
  logic        iResValid = 1'b0;
  logic [31:0] iResPC = '0;
  logic        iResTaken = 1'b0;
  logic        iResLink = 1'b0;
  logic [31:0] iResTarget = '0;
  logic        iResPredTaken = 1'b0;
  logic [31:0] iResPredTarget = '0;
  logic        oMispredict;
  logic [31:0] oRedirectPC;
  logic        oLinkWe;
  logic [31:0] oLinkPC;
  logic [31:0] oStatBranches;
  logic [31:0] oStatMispred;

  branch_predictor_pipem dut (
    .iCLK(iCLK), .iRST(iRST), .iFetchPC(iFetchPC),
    .oPredTaken(oPredTaken), .oPredTarget(oPredTarget),
    .iResValid(iResValid), .iResPC(iResPC), .iResTaken(iResTaken),
    .iResLink(iResLink), .iResTarget(iResTarget),
    .iResPredTaken(iResPredTaken), .iResPredTarget(iResPredTarget),
    .oMispredict(oMispredict), .oRedirectPC(oRedirectPC),
    .oLinkWe(oLinkWe), .oLinkPC(oLinkPC),
    .oStatBranches(oStatBranches), .oStatMispred(oStatMispred)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] fpc;
    logic        rv;
    logic [31:0] rpc;
    logic        tk;
    logic        lk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red;
    logic        e_lwe;
    logic [31:0] e_lpc;
  } vec_t;

  typedef struct {
    logic        mis;
    logic [31:0] red;
    logic        lwe;
    logic [31:0] lpc;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_red = '0;
  logic [31:0] m_lpc = '0;
  logic [31:0] m_sb  = '0;
  logic [31:0] m_sm  = '0;

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_1010;
  localparam logic [31:0] PL = 32'h0040_0100;
  localparam logic [31:0] PW = 32'hFFFF_FFFC;

  function automatic vec_t mk(logic [31:0] fpc, logic rv, logic [31:0] rpc, logic tk, logic lk,
                              logic [31:0] tgt, logic ptk, logic [31:0] ptgt, logic e_pt,
                              logic [31:0] e_ptgt, logic e_mis, logic [31:0] e_red,
                              logic e_lwe, logic [31:0] e_lpc);
    vec_t v;
    v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.tk = tk; v.lk = lk; v.tgt = tgt;
    v.ptk = ptk; v.ptgt = ptgt; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mis = e_mis;
    v.e_red = e_red; v.e_lwe = e_lwe; v.e_lpc = e_lpc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(logic [31:0] v);
`ifdef BRANCH_PREDICTOR_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic check_regs(string tag, exp_t e);
    check({tag, " oMispredict"}, {31'b0, oMispredict}, {31'b0, e.mis});
    check({tag, " oRedirectPC"}, oRedirectPC, e.red);
    check({tag, " oLinkWe"}, {31'b0, oLinkWe}, {31'b0, e.lwe});
    check({tag, " oLinkPC"}, oLinkPC, e.lpc);
    check({tag, " oStatBranches"}, oStatBranches, e.sb);
    check({tag, " oStatMispred"}, oStatMispred, e.sm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs.push_back(mk(PA, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0014, 0, 0, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 1, 0, 32'h0040_0040, 0, 32'h0040_0014, 0, 32'h0040_0014, 1, 32'h0040_0040, 0, 0));
    vecs.push_back(mk(PA, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0040, 0, 0, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 0, 0, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0014, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 0, 0, 32'h0040_0040, 0, 32'h0040_0014, 0, 32'h0040_0014, 0, 0, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 0, 0, 32'h0040_0040, 0, 32'h0040_0014, 0, 32'h0040_0014, 0, 0, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 1, 0, 32'h0040_0040, 0, 32'h0040_0014, 0, 32'h0040_0014, 1, 32'h0040_0040, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 1, 0, 32'h0040_0040, 0, 32'h0040_0014, 0, 32'h0040_0014, 1, 32'h0040_0040, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 1, 0, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0040, 0, 0, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 1, 0, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0040, 0, 0, 0, 0));
    vecs.push_back(mk(PA, 1, PA, 0, 0, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0040, 1, 32'h0040_0014, 0, 0));
    vecs.push_back(mk(PA, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0040, 0, 0, 0, 0));
    vecs.push_back(mk(PA, 1, PB, 1, 0, 32'h0040_2000, 0, 32'h0040_1014, 1, 32'h0040_0040, 1, 32'h0040_2000, 0, 0));
    vecs.push_back(mk(PA, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0014, 0, 0, 0, 0));
    vecs.push_back(mk(PB, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_2000, 0, 0, 0, 0));
    vecs.push_back(mk(PB, 1, PB, 1, 0, 32'h0040_3000, 1, 32'h0040_2000, 1, 32'h0040_2000, 1, 32'h0040_3000, 0, 0));
    vecs.push_back(mk(PB, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_3000, 0, 0, 0, 0));
    vecs.push_back(mk(PL, 1, PL, 1, 1, 32'h0040_0800, 1, 32'h0040_0800, 0, 32'h0040_0104, 0, 0, 1, 32'h0040_0108));
    vecs.push_back(mk(PL, 1, PL, 0, 1, 32'h0040_0800, 1, 32'h0040_0800, 1, 32'h0040_0800, 1, 32'h0040_0104, 0, 0));
    vecs.push_back(mk(PL, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0104, 0, 0, 0, 0));
    vecs.push_back(mk(PW, 1, PW, 0, 0, 32'h0000_1000, 1, 32'h0000_1000, 0, 32'h0000_0000, 1, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(PW, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0, 0));

    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    #1;
    e = '{mis: 1'b0, red: 32'h0, lwe: 1'b0, lpc: 32'h0, sb: 32'h0, sm: 32'h0};
    check_regs("reset", e);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge iCLK);
      iFetchPC       = vecs[i].fpc;
      iResValid      = vecs[i].rv;
      iResPC         = vecs[i].rpc;
      iResTaken      = vecs[i].tk;
      iResLink       = vecs[i].lk;
      iResTarget     = vecs[i].tgt;
      iResPredTaken  = vecs[i].ptk;
      iResPredTarget = vecs[i].ptgt;
      #1;
      check($sformatf("v%0d oPredTaken", i), {31'b0, oPredTaken}, {31'b0, vecs[i].e_pt});
      check($sformatf("v%0d oPredTarget", i), oPredTarget, vecs[i].e_ptgt);
      if (vecs[i].e_mis) m_red = vecs[i].e_red;
      if (vecs[i].e_lwe) m_lpc = vecs[i].e_lpc;
      if (vecs[i].rv) m_sb = m_sb + 32'd1;
      if (vecs[i].e_mis) m_sm = m_sm + 32'd1;
      sb_q.push_back('{mis: vecs[i].e_mis, red: m_red, lwe: vecs[i].e_lwe, lpc: m_lpc,
                       sb: stat_exp(m_sb), sm: stat_exp(m_sm)});
      @(posedge iCLK);
      #1;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", i);
      end else begin
        e = sb_q.pop_front();
        check_regs($sformatf("v%0d", i), e);
      end
    end

    // Reset raised together with a resolving linking branch: nothing may land.
    @(negedge iCLK);
    iFetchPC       = 32'h0040_0024;
    iResValid      = 1'b1;
    iResPC         = 32'h0040_0024;
    iResTaken      = 1'b1;
    iResLink       = 1'b1;
    iResTarget     = 32'h0040_0900;
    iResPredTaken  = 1'b0;
    iResPredTarget = 32'h0040_0028;
    iRST           = 1'b1;
    @(posedge iCLK);
    #1;
    e = '{mis: 1'b0, red: 32'h0, lwe: 1'b0, lpc: 32'h0, sb: 32'h0, sm: 32'h0};
    check_regs("rst_mid", e);
    @(negedge iCLK);
    iResValid = 1'b0;
    iRST      = 1'b0;
    #1;
    check("rst_mid lookup taken", {31'b0, oPredTaken}, 32'h0);
    check("rst_mid lookup target", oPredTarget, 32'h0040_0028);
    iFetchPC = PB;
    #1;
    check("rst_clear B taken", {31'b0, oPredTaken}, 32'h0);
    check("rst_clear B target", oPredTarget, 32'h0040_1014);
    @(posedge iCLK);
    #1;
    check_regs("post_rst", e);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
